// File: rtl/button_debouncer_if.sv
// Button-side bundle for the debouncer: raw buttons in, debounced level and press pulse out.
interface button_debouncer_if #(
  parameter int NB_BTN = 4
);
  logic [NB_BTN-1:0] i_btn;
  logic [NB_BTN-1:0] o_level;
  logic [NB_BTN-1:0] o_pulse;

  modport master (output i_btn, input  o_level, input  o_pulse);
  modport slave  (input  i_btn, output o_level, output o_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Per-button 2-flop synchronizer, consecutive-disagreement debounce filter and
// registered rising-edge press pulse; all channels independent.
module button_debouncer #(
  parameter int NB_BTN          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = 20
) (
  input  logic                i_clk,
  input  logic                i_reset,
  button_debouncer_if.slave   bus
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [NB_BTN-1:0] sync1_q, sync2_q;
  logic [NB_BTN-1:0] level_q, level_d;
  logic [NB_BTN-1:0] pulse_q, pulse_d;
  logic [NB_CNT-1:0] cnt_q [NB_BTN];
  logic [NB_CNT-1:0] cnt_d [NB_BTN];

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < NB_BTN; i++) begin
      cnt_d[i] = '0;
      // Any edge where sync agrees with the level leaves the count at zero.
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < NB_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < NB_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.o_level = level_q;
  assign bus.o_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized
// bouncing inputs compared against a sliding-window reference model.
module tb_button_debouncer;

  localparam int NB  = 4;
  localparam int D   = 4;
  localparam int NBC = 3;
  localparam logic [31:0] WMASK = (32'd1 << D) - 32'd1;

  logic i_clk;
  logic i_reset;

  button_debouncer_if #(.NB_BTN(NB)) btn_if ();

  button_debouncer #(
    .NB_BTN          (NB),
    .DEBOUNCE_CYCLES (D),
    .NB_CNT          (NBC)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (btn_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: sync is the raw input delayed by two edges; the level flips once the
  // last D sync samples since the previous flip (or reset) all differ from it.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
  logic [31:0]   m_hist [NB];
  int            m_nhist [NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c]  = '0;
      m_nhist[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] raw);
    m_pulse = '0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c] = {m_hist[c][30:0], m_s2[c]};
      if (m_nhist[c] < 1000) m_nhist[c]++;
      if (m_nhist[c] >= D && (m_hist[c] & WMASK) == (m_lvl[c] ? 32'd0 : WMASK)) begin
        m_lvl[c]   = ~m_lvl[c];
        m_pulse[c] = m_lvl[c];
        m_nhist[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Called at a negedge; drives raw input, lets one edge pass, checks, returns at next negedge.
  task automatic step(input logic [NB-1:0] v);
    btn_if.i_btn = v;
    @(posedge i_clk);
    model_edge(v);
    #1;
    check("model_lvl", 32'(btn_if.o_level), 32'(m_lvl));
    check("model_pls", 32'(btn_if.o_pulse), 32'(m_pulse));
    @(negedge i_clk);
  endtask

  task automatic do_reset(input logic [NB-1:0] v);
    btn_if.i_btn = v;
    i_reset = 1'b1;
    #1;
    check("rst_lvl", 32'(btn_if.o_level), 32'd0);
    check("rst_pls", 32'(btn_if.o_pulse), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_hold_lvl", 32'(btn_if.o_level), 32'd0);
    i_reset = 1'b0;
    model_reset();
  endtask

  logic [NB-1:0] base, glitch;
  logic [7:0]    bounce_pat;

  initial begin
    i_reset = 1'b1;
    btn_if.i_btn = '0;
    model_reset();
    @(negedge i_clk);

    // Button held through reset release
    do_reset(4'b1111);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111);
      check("rel_lvl", 32'(btn_if.o_level), (k >= 5) ? 32'hF : 32'h0);
      check("rel_pls", 32'(btn_if.o_pulse), (k == 5) ? 32'hF : 32'h0);
    end

    // Clean press on channel 0
    do_reset(4'b0000);
    for (int k = 0; k < 9; k++) begin
      step(4'b0001);
      check("press_lvl", 32'(btn_if.o_level), (k >= 5) ? 32'h1 : 32'h0);
      check("press_pls", 32'(btn_if.o_pulse), (k == 5) ? 32'h1 : 32'h0);
    end

    // Bounce on channel 1: 1,1,1,0 then held high
    do_reset(4'b0000);
    bounce_pat = 8'b1111_0111;
    for (int k = 0; k < 13; k++) begin
      step((k < 8 && !bounce_pat[k]) ? 4'b0000 : 4'b0010);
      check("bnc_lvl", 32'(btn_if.o_level), (k >= 9) ? 32'h2 : 32'h0);
      check("bnc_pls", 32'(btn_if.o_pulse), (k == 9) ? 32'h2 : 32'h0);
    end

    // Short glitch on channel 2
    do_reset(4'b0000);
    for (int k = 0; k < 12; k++) begin
      step((k < 3) ? 4'b0100 : 4'b0000);
      check("glt_lvl", 32'(btn_if.o_level), 32'h0);
      check("glt_pls", 32'(btn_if.o_pulse), 32'h0);
    end

    // Release of channel 3, then reset in the middle of the next press
    do_reset(4'b0000);
    for (int k = 0; k < 7; k++) step(4'b1000);
    check("hold3_lvl", 32'(btn_if.o_level), 32'h8);
    for (int k = 0; k < 8; k++) begin
      step(4'b0000);
      check("fall_lvl", 32'(btn_if.o_level), (k < 5) ? 32'h8 : 32'h0);
      check("fall_pls", 32'(btn_if.o_pulse), 32'h0);
    end
    for (int k = 0; k < 3; k++) step(4'b1000);
    do_reset(4'b1000);
    for (int k = 0; k < 8; k++) begin
      step(4'b1000);
      check("rep_lvl", 32'(btn_if.o_level), (k >= 5) ? 32'h8 : 32'h0);
      check("rep_pls", 32'(btn_if.o_pulse), (k == 5) ? 32'h8 : 32'h0);
    end

    // Concurrent press on channels 0 and 1
    do_reset(4'b0000);
    for (int k = 0; k < 8; k++) begin
      step(4'b0011);
      check("conc_pls", 32'(btn_if.o_pulse), (k == 5) ? 32'h3 : 32'h0);
    end

    // Randomized bouncing buttons with occasional asynchronous reset
    do_reset(4'b0000);
    base = '0;
    for (int n = 0; n < 4000; n++) begin
      glitch = '0;
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 11) == 0) base[c] = ~base[c];
        if ($urandom_range(0, 9) == 0)  glitch[c] = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4));
        do_reset(base);
      end else begin
        step(base ^ glitch);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Conditions raw push-button inputs before they reach the operand/opcode load logic of the ALU top level. Each button goes through its own 2-flop synchronizer, a debounce filter and a rising-edge detector. The block produces a clean level and a one-cycle press pulse per button. The pulses drive the load strobes for operand A, operand B and opcode, and the register-clear strobe, so each press loads exactly once.

Parameters:
NB_BTN, 4, number of independent button channels (bit 0..NB_BTN-1).
DEBOUNCE_CYCLES, 1000000, consecutive clock cycles a synchronized input must differ from the filtered level before the level changes; legal range 2..2^24.
NB_CNT, 20, width of each per-channel debounce counter; must satisfy 2^NB_CNT > DEBOUNCE_CYCLES.

Ports:
i_clk  input  1  system clock; all state on rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_btn  input  NB_BTN  raw, asynchronous, bouncing button inputs; active-high.
o_level  output  NB_BTN  debounced button level, registered.
o_pulse  output  NB_BTN  one-cycle pulse on each debounced 0->1 transition, registered.

Behaviour:
- Reset (async assert, sync use on release): synchronizer flops, counters, o_level and o_pulse all 0. Reset mid-count discards progress. Reset mid-pulse drops the pulse immediately.
- Synchronizer: per channel, 2 flops; sync = second flop. No logic between the flops.
- Channels are fully independent. No shared counter and no cross-channel priority.
- Filter, per channel, evaluated each edge:
  - if sync == o_level: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: o_level <= sync, counter <= 0.
  - else: counter <= counter+1.
  - o_level therefore changes on the DEBOUNCE_CYCLES-th consecutive edge at which sync differs from o_level.
  - Any single cycle of agreement (a bounce) restarts the count from 0.
- Latency: i_btn stable across edge k changes o_level at edge k+1+DEBOUNCE_CYCLES (2 synchronizer edges + DEBOUNCE_CYCLES-1 count edges + the update edge). The same latency applies to press and release.
- Pulse: o_pulse[i] <= (filter sets o_level[i] 0->1 on this edge). It is high for exactly the one cycle in which o_level[i] first reads 1, and 0 otherwise. There is no pulse on release.
- A held button gives one pulse per press, with no auto-repeat.
- Button held through reset release: o_level starts at 0, then rises after the normal latency with one pulse. This is accepted behaviour.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous events on several channels can produce pulses in the same cycle. The consumer resolves priority.
- Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization never reach o_level or o_pulse.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold i_reset=1 with i_btn=4'b1111 -> o_level=0 and o_pulse=0 while reset is asserted. After release, channel 0..3 o_level=1 at edge 6 after release, each with a single o_pulse cycle.
- Clean press, D=4: i_btn[0] 0->1 before edge 0 and held -> o_level[0]=1 after edge 5, o_pulse[0]=1 for that one cycle only. Other channels stay 0.
- Bounce, D=4: i_btn[1] pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> count restarts at the 0. o_level[1] rises 5 edges after the last restart point; exactly one pulse.
- Short glitch, D=4: i_btn[2] high for 3 cycles then low -> o_level[2] and o_pulse[2] stay 0 throughout.
- Release and reset mid-count, D=4: held channel 3 released -> o_level[3] falls after 5 edges with no pulse. Press again, assert i_reset after 3 edges -> outputs 0 immediately. After release, full 5-edge latency again before the pulse.
- Concurrent, D=4: i_btn 4'b0011 rising together -> o_pulse=4'b0011 in the same single cycle.
